// File: rtl/demux_rr_dispatcher.sv
// Round-robin 1-to-4 dispatcher: a one-word holding register steers each accepted
// word to the next enabled channel and counts delivered words per channel.
module demux_rr_dispatcher #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din_valid,
   output logic                din_ready,
   input  logic [DATA_W-1:0]   din_data,
   input  logic [3:0]          chan_en,
   output logic [3:0]          z_valid,
   input  logic [3:0]          z_ready,
   output logic [DATA_W-1:0]   z_data,
   output logic [1:0]          cur_sel,
   output logic                busy,
   output logic [4*CNT_W-1:0]  cnt
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t              r_state;
   logic [1:0]          r_ptr;
   logic [1:0]          r_sel;
   logic [DATA_W-1:0]   r_data;
   logic [CNT_W-1:0]    r_cnt [4];

   logic                w_has_tgt;
   logic [1:0]          w_tgt;
   logic                w_out_xfer;
   logic                w_in_xfer;

   // Scan from the farthest offset down so the nearest enabled channel to r_ptr wins.
   always_comb begin
      w_has_tgt = 1'b0;
      w_tgt     = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (chan_en[r_ptr + 2'(k)]) begin
            w_has_tgt = 1'b1;
            w_tgt     = r_ptr + 2'(k);
         end
      end
   end

   assign w_out_xfer = (r_state == ST_FULL) && z_ready[r_sel];
   assign din_ready  = w_has_tgt && ((r_state == ST_EMPTY) || w_out_xfer);
   assign w_in_xfer  = din_valid && din_ready;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; the counter array is only four registers, so it is reset
   // explicitly rather than treated as an unreset memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_ptr   <= 2'd0;
         r_sel   <= 2'd0;
         r_data  <= '0;
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         if (w_in_xfer) begin
            r_data  <= din_data;
            r_sel   <= w_tgt;
            r_ptr   <= w_tgt + 2'd1;
            r_state <= ST_FULL;
         end else if (w_out_xfer) begin
            r_state <= ST_EMPTY;
         end
         if (w_out_xfer) begin
            r_cnt[r_sel] <= r_cnt[r_sel] + CNT_W'(1);
         end
      end
   end

   assign z_valid = (r_state == ST_FULL) ? (4'b0001 << r_sel) : 4'b0000;
   assign z_data  = r_data;
   assign cur_sel = r_sel;
   assign busy    = (r_state == ST_FULL);

   for (genvar g = 0; g < 4; g++) begin : g_cnt
      assign cnt[g*CNT_W +: CNT_W] = r_cnt[g];
   end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher: round-robin order, skipping, back-pressure,
// late disable of a held channel, no-enable stall, counter wrap and mid-run reset.
module tb_demux_rr_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        din_valid;
   logic        din_ready;
   logic [7:0]  din_data;
   logic [3:0]  chan_en;
   logic [3:0]  z_valid;
   logic [3:0]  z_ready;
   logic [7:0]  z_data;
   logic [1:0]  cur_sel;
   logic        busy;
   logic [31:0] cnt;

   logic        rst2;
   logic        din_valid2;
   logic        din_ready2;
   logic [7:0]  din_data2;
   logic [3:0]  chan_en2;
   logic [3:0]  z_valid2;
   logic [3:0]  z_ready2;
   logic [7:0]  z_data2;
   logic [1:0]  cur_sel2;
   logic        busy2;
   logic [7:0]  cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   demux_rr_dispatcher #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
      .din_data(din_data), .chan_en(chan_en), .z_valid(z_valid), .z_ready(z_ready),
      .z_data(z_data), .cur_sel(cur_sel), .busy(busy), .cnt(cnt)
   );

   demux_rr_dispatcher #(.DATA_W(8), .CNT_W(2)) dut_w2 (
      .clk(clk), .rst(rst2), .din_valid(din_valid2), .din_ready(din_ready2),
      .din_data(din_data2), .chan_en(chan_en2), .z_valid(z_valid2), .z_ready(z_ready2),
      .z_data(z_data2), .cur_sel(cur_sel2), .busy(busy2), .cnt(cnt2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; din_valid = 1'b0; din_data = 8'h00; chan_en = 4'b0000; z_ready = 4'b0000;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy act=%b exp=0", busy); end
      n_tests++; if (z_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_zvalid act=%b exp=0000", z_valid); end
      n_tests++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL reset_cursel act=%0d exp=0", cur_sel); end
      n_tests++; if (z_data !== 8'h00) begin n_fail++; $display("FAIL reset_zdata act=%h exp=00", z_data); end
      n_tests++; if (cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt act=%h exp=00000000", cnt); end
      n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_noen act=%b exp=0", din_ready); end
      chan_en = 4'b1111;
      #1;
      n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_en act=%b exp=1", din_ready); end
   endtask

   // Back-to-back stream over all four channels, one word per cycle.
   task automatic test_back_to_back();
      logic [3:0] exp_zv;
      logic [7:0] exp_d;
      do_reset();
      chan_en = 4'b1111; z_ready = 4'b1111;
      for (int i = 0; i <= 8; i++) begin
         din_valid = (i < 8);
         din_data  = 8'hA0 + 8'(i);
         @(negedge clk);
         exp_zv = (i == 0) ? 4'b0000 : (4'b0001 << ((i - 1) % 4));
         exp_d  = 8'hA0 + 8'(i - 1);
         n_tests++; if (z_valid !== exp_zv) begin n_fail++; $display("FAIL b2b_zvalid[%0d] act=%b exp=%b", i, z_valid, exp_zv); end
         if (i > 0) begin
            n_tests++; if (z_data !== exp_d) begin n_fail++; $display("FAIL b2b_zdata[%0d] act=%h exp=%h", i, z_data, exp_d); end
         end
         n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] act=%b exp=1", i, din_ready); end
         step();
      end
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drained act=%b exp=0", busy); end
      n_tests++; if (z_data !== 8'hA7) begin n_fail++; $display("FAIL b2b_zdata_keep act=%h exp=a7", z_data); end
      n_tests++; if (cnt !== {4{8'd2}}) begin n_fail++; $display("FAIL b2b_cnt act=%h exp=02020202", cnt); end
   endtask

   task automatic test_skip();
      logic [1:0] exp_ch [4];
      exp_ch = '{2'd1, 2'd3, 2'd1, 2'd3};
      do_reset();
      chan_en = 4'b1010; z_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         din_valid = 1'b1;
         din_data  = 8'h11 + 8'(i);
         step();
         din_valid = 1'b0;
         @(negedge clk);
         n_tests++; if (z_valid !== (4'b0001 << exp_ch[i])) begin n_fail++; $display("FAIL skip_zvalid[%0d] act=%b exp_ch=%0d", i, z_valid, exp_ch[i]); end
         n_tests++; if (z_data !== 8'h11 + 8'(i)) begin n_fail++; $display("FAIL skip_zdata[%0d] act=%h exp=%h", i, z_data, 8'h11 + 8'(i)); end
      end
      step();
      @(negedge clk);
      n_tests++; if (cnt !== {8'd2, 8'd0, 8'd2, 8'd0}) begin n_fail++; $display("FAIL skip_cnt act=%h exp=02000200", cnt); end
   endtask

   task automatic test_backpressure();
      do_reset();
      chan_en = 4'b1111; z_ready = 4'b0000; din_valid = 1'b1; din_data = 8'h55;
      @(negedge clk);
      n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_empty act=%b exp=1", din_ready); end
      step();
      din_data = 8'h66;
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0001) begin n_fail++; $display("FAIL bp_zvalid_held act=%b exp=0001", z_valid); end
      n_tests++; if (z_data !== 8'h55) begin n_fail++; $display("FAIL bp_zdata_held act=%h exp=55", z_data); end
      n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full act=%b exp=0", din_ready); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy act=%b exp=1", busy); end
      step();
      @(negedge clk);
      n_tests++; if (z_data !== 8'h55) begin n_fail++; $display("FAIL bp_zdata_stall act=%h exp=55", z_data); end
      step();
      z_ready = 4'b0001;
      @(negedge clk);
      n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_xfer act=%b exp=1", din_ready); end
      step();
      din_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_zvalid_next act=%b exp=0010", z_valid); end
      n_tests++; if (z_data !== 8'h66) begin n_fail++; $display("FAIL bp_zdata_next act=%h exp=66", z_data); end
      n_tests++; if (cur_sel !== 2'd1) begin n_fail++; $display("FAIL bp_cursel act=%0d exp=1", cur_sel); end
      n_tests++; if (cnt !== 32'h0000_0001) begin n_fail++; $display("FAIL bp_cnt0 act=%h exp=00000001", cnt); end
      step();
      z_ready = 4'b0010;
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_ignore_other_ready act=%b exp=0010", z_valid); end
      step();
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drained act=%b exp=0000", z_valid); end
      n_tests++; if (cnt !== 32'h0000_0101) begin n_fail++; $display("FAIL bp_cnt01 act=%h exp=00000101", cnt); end
   endtask

   task automatic test_disable_held();
      logic [1:0] exp_ch [4];
      exp_ch = '{2'd3, 2'd0, 2'd1, 2'd3};
      do_reset();
      chan_en = 4'b0100; z_ready = 4'b0000; din_valid = 1'b1; din_data = 8'h77;
      step();
      din_valid = 1'b0; chan_en = 4'b1011;
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0100) begin n_fail++; $display("FAIL dis_zvalid act=%b exp=0100", z_valid); end
      n_tests++; if (cur_sel !== 2'd2) begin n_fail++; $display("FAIL dis_cursel act=%0d exp=2", cur_sel); end
      n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready act=%b exp=0", din_ready); end
      step();
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0100) begin n_fail++; $display("FAIL dis_zvalid_stay act=%b exp=0100", z_valid); end
      step();
      z_ready = 4'b0100;
      step();
      z_ready = 4'b1111;
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0000) begin n_fail++; $display("FAIL dis_drained act=%b exp=0000", z_valid); end
      n_tests++; if (cnt !== 32'h0001_0000) begin n_fail++; $display("FAIL dis_cnt2 act=%h exp=00010000", cnt); end
      for (int i = 0; i < 4; i++) begin
         din_valid = 1'b1;
         din_data  = 8'h78 + 8'(i);
         step();
         din_valid = 1'b0;
         @(negedge clk);
         n_tests++; if (z_valid !== (4'b0001 << exp_ch[i])) begin n_fail++; $display("FAIL dis_skip[%0d] act=%b exp_ch=%0d", i, z_valid, exp_ch[i]); end
      end
   endtask

   task automatic test_no_enable();
      do_reset();
      chan_en = 4'b0000; z_ready = 4'b1111; din_valid = 1'b1; din_data = 8'h99;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL noen_ready[%0d] act=%b exp=0", i, din_ready); end
         n_tests++; if (z_valid !== 4'b0000) begin n_fail++; $display("FAIL noen_zvalid[%0d] act=%b exp=0000", i, z_valid); end
         step();
      end
      chan_en = 4'b0100;
      @(negedge clk);
      n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL noen_ready_en act=%b exp=1", din_ready); end
      step();
      din_valid = 1'b0; chan_en = 4'b0000;
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0100) begin n_fail++; $display("FAIL noen_zvalid_ch2 act=%b exp=0100", z_valid); end
      n_tests++; if (z_data !== 8'h99) begin n_fail++; $display("FAIL noen_zdata act=%h exp=99", z_data); end
      step();
      @(negedge clk);
      n_tests++; if (z_valid !== 4'b0000) begin n_fail++; $display("FAIL noen_drain act=%b exp=0000", z_valid); end
      n_tests++; if (cnt !== 32'h0001_0000) begin n_fail++; $display("FAIL noen_cnt act=%h exp=00010000", cnt); end
   endtask

   task automatic test_wrap_and_reset();
      rst2 = 1'b1;
      step();
      step();
      rst2 = 1'b0; chan_en2 = 4'b0001; z_ready2 = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         din_valid2 = 1'b1;
         din_data2  = 8'(i);
         @(negedge clk);
         n_tests++; if (din_ready2 !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d] act=%b exp=1", i, din_ready2); end
         step();
      end
      din_valid2 = 1'b0;
      step();
      @(negedge clk);
      n_tests++; if (cnt2 !== 8'h01) begin n_fail++; $display("FAIL wrap_cnt act=%h exp=01", cnt2); end
      z_ready2 = 4'b0000; din_valid2 = 1'b1; din_data2 = 8'h5A;
      step();
      din_valid2 = 1'b0;
      @(negedge clk);
      n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL wrap_busy act=%b exp=1", busy2); end
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      @(negedge clk);
      n_tests++; if (z_valid2 !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_zvalid act=%b exp=0000", z_valid2); end
      n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy act=%b exp=0", busy2); end
      n_tests++; if (cnt2 !== 8'h00) begin n_fail++; $display("FAIL rst_mid_cnt act=%h exp=00", cnt2); end
   endtask

   initial begin
      rst = 1'b1; din_valid = 1'b0; din_data = 8'h00; chan_en = 4'b0000; z_ready = 4'b0000;
      rst2 = 1'b1; din_valid2 = 1'b0; din_data2 = 8'h00; chan_en2 = 4'b0000; z_ready2 = 4'b0000;
      test_reset();
      test_back_to_back();
      test_skip();
      test_backpressure();
      test_disable_held();
      test_no_enable();
      test_wrap_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
